// File: rtl/rx_cic_pkg.sv
// rx_cic_pkg: shared constants and settings types for the RX CIC decimator.
// Register map offsets are relative to the instance BASE address.
package rx_cic_pkg;

  localparam int RATE_W    = 8;
  localparam int SHIFT_W   = 6;
  localparam int MAX_SHIFT = 32;
  localparam int OFF_RATE  = 0;
  localparam int OFF_SHIFT = 1;

  typedef struct packed {
    logic [RATE_W-1:0]  rate;
    logic [SHIFT_W-1:0] shift;
  } cic_cfg_t;

  function automatic logic [SHIFT_W-1:0] clamp_shift(
    input logic [SHIFT_W-1:0] s
  );
    return (s > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : s;
  endfunction

  // Rates 0 and 1 both mean "every cycle".
  function automatic logic [RATE_W-1:0] rate_reload(
    input logic [RATE_W-1:0] r
  );
    return (r > RATE_W'(1)) ? r - RATE_W'(1) : '0;
  endfunction

endpackage

// File: rtl/rx_cic_lane.sv
// rx_cic_lane: one channel of integrators, pipelined combs, shift and clip.
// Build with RX_CIC_ROUND_EN to round half away from zero before the clip.
module rx_cic_lane
  import rx_cic_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int STAGES = 4,
  parameter int AW     = WIDTH + STAGES * 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               samp_en,
  input  logic [STAGES-1:0]  comb_en,
  input  logic               out_en,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout
);

  logic [AW-1:0] integ_q [STAGES];
  logic [AW-1:0] integ_d [STAGES];
  logic [AW-1:0] acc;
  logic [AW-1:0] p   [STAGES+1];
  logic [AW-1:0] dly [STAGES];

  logic [SHIFT_W-1:0] sh;
  logic [AW-1:0]      rnd;
  logic [AW-1:0]      shd;
  logic [AW-WIDTH:0]  hi;
  logic [WIDTH-1:0]   sat;

  // Cascade folded into a running sum so every stage sees this cycle's input.
  always_comb begin
    acc = {{(AW-WIDTH){din[WIDTH-1]}}, din};
    for (int k = 0; k < STAGES; k++) begin
      acc        = acc + integ_q[k];
      integ_d[k] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) integ_q[k] <= integ_d[k];
    end
  end

  // p[0] holds the decimated sample; p[k+1] is comb stage k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) p[k] <= '0;
      for (int k = 0; k < STAGES; k++) dly[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k <= STAGES; k++) p[k] <= '0;
      for (int k = 0; k < STAGES; k++) dly[k] <= '0;
    end else begin
      if (samp_en) p[0] <= integ_d[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        if (comb_en[k]) begin
          p[k+1] <= p[k] - dly[k];
          dly[k] <= p[k];
        end
      end
    end
  end

  always_comb begin
    sh  = clamp_shift(shift);
    rnd = p[STAGES];
`ifdef RX_CIC_ROUND_EN
    // Negative values take half minus one so ties move away from zero.
    if (sh != '0) begin
      rnd = p[STAGES] + (AW'(1) << (sh - 1'b1))
          - AW'(p[STAGES][AW-1]);
    end
`endif
    shd = $signed(rnd) >>> sh;
    hi  = shd[AW-1:WIDTH-1];
    if (&hi || ~|hi) begin
      sat = shd[WIDTH-1:0];
    end else if (hi[AW-WIDTH]) begin
      sat = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (out_en) begin
      dout <= sat;
    end
  end

endmodule

// File: rtl/rx_cic_decim.sv
// rx_cic_decim: I/Q CIC decimator with settings-bus rate and shift registers.
// Optional RX_CIC_ROUND_EN enables round-half-away-from-zero in each lane.
module rx_cic_decim
  import rx_cic_pkg::*;
#(
  parameter int BASE   = 0,
  parameter int WIDTH  = 24,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic             run,
  input  logic [WIDTH-1:0] i_in,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] i_out,
  output logic [WIDTH-1:0] q_out,
  output logic             strobe_out
);

  localparam int AW = WIDTH + STAGES * 8;
  localparam int WW = $clog2(STAGES + 1);

  cic_cfg_t          cfg;
  logic              rate_wr;
  logic              shift_wr;
  logic              flush;
  logic              dec_evt;
  logic              warm_done;
  logic              out_en;
  logic [RATE_W-1:0] cnt;
  logic [WW-1:0]     warm;
  logic [STAGES-1:0] tick;
  logic [STAGES:0]   good;
  logic              unused_data;

  assign rate_wr     = set_stb && (set_addr == 8'(BASE + OFF_RATE));
  assign shift_wr    = set_stb && (set_addr == 8'(BASE + OFF_SHIFT));
  // A rate write flushes for its own cycle; the new rate applies next cycle.
  assign flush       = !run || rate_wr;
  assign dec_evt     = !flush && (cnt == '0);
  assign warm_done   = (warm == WW'(STAGES));
  assign out_en      = good[STAGES] && !flush;
  assign unused_data = ^set_data[31:RATE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else begin
      if (rate_wr)  cfg.rate  <= set_data[RATE_W-1:0];
      if (shift_wr) cfg.shift <= set_data[SHIFT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= rate_reload(cfg.rate);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Comb delays need STAGES events to fill before outputs are trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm <= '0;
    end else if (flush) begin
      warm <= '0;
    end else if (dec_evt && !warm_done) begin
      warm <= warm + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick       <= '0;
      good       <= '0;
      strobe_out <= 1'b0;
    end else if (flush) begin
      tick       <= '0;
      good       <= '0;
      strobe_out <= 1'b0;
    end else begin
      tick       <= STAGES'({tick, dec_evt});
      good       <= {good[STAGES-1:0], dec_evt && warm_done};
      strobe_out <= good[STAGES];
    end
  end

  rx_cic_lane #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .AW     (AW)
  ) u_lane_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .samp_en (dec_evt),
    .comb_en (tick),
    .out_en  (out_en),
    .shift   (cfg.shift),
    .din     (i_in),
    .dout    (i_out)
  );

  rx_cic_lane #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .AW     (AW)
  ) u_lane_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .samp_en (dec_evt),
    .comb_en (tick),
    .out_en  (out_en),
    .shift   (cfg.shift),
    .din     (q_in),
    .dout    (q_out)
  );

endmodule

// File: tb/tb_rx_cic_decim.sv
// tb_rx_cic_decim: directed vectors with hand-computed results for the CIC.
// Rounding-dependent expectations follow RX_CIC_ROUND_EN.
module tb_rx_cic_decim;

  localparam int BASE   = 0;
  localparam int WIDTH  = 24;
  localparam int STAGES = 4;

`ifdef RX_CIC_ROUND_EN
  localparam int EXP_P6 = 2;
`else
  localparam int EXP_P6 = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             set_stb;
  logic [7:0]       set_addr;
  logic [31:0]      set_data;
  logic             run;
  logic [WIDTH-1:0] i_in;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] i_out;
  logic [WIDTH-1:0] q_out;
  logic             strobe_out;

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  int hq[$];

  always #5 clk = ~clk;

  rx_cic_decim #(
    .BASE   (BASE),
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .run        (run),
    .i_in       (i_in),
    .q_in       (q_in),
    .i_out      (i_out),
    .q_out      (q_out),
    .strobe_out (strobe_out)
  );

  function automatic logic signed [31:0] sx(input logic [WIDTH-1:0] v);
    return {{(32-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    set_stb  = 1'b1;
    set_addr = 8'(addr);
    set_data = 32'(data);
    cyc();
    set_stb  = 1'b0;
  endtask

  task automatic wait_stb(input int max, output int cnt);
    cnt = 0;
    while (!strobe_out && cnt < max) begin
      cyc();
      cnt++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    run      = 1'b0;
    i_in     = '0;
    q_in     = '0;
    repeat (3) cyc();
    chk("rst_i", sx(i_out), 0);
    chk("rst_q", sx(q_out), 0);
    chk("rst_stb", 32'(strobe_out), 0);
    rst_n = 1'b1;
    cyc();

    // R=4, S=8: gain 256 shifted back out, 1000 in -> 1000 out
    wr(BASE, 4);
    wr(BASE + 1, 8);
    i_in = 24'd1000;
    q_in = -24'sd1000;
    run  = 1'b1;
    wait_stb(40, n);
    chk("a_first", n, 22);
    chk("a_i", sx(i_out), 1000);
    chk("a_q", sx(q_out), -1000);
    for (int k = 0; k < 3; k++) begin
      cyc();
      wait_stb(10, n);
      chk("a_gap", n + 1, 4);
      chk("a_val", sx(i_out), 1000);
    end

    // Drop run one cycle before a strobe is due
    repeat (3) cyc();
    run = 1'b0;
    cyc();
    chk("d_stb_off", 32'(strobe_out), 0);
    chk("d_hold", sx(i_out), 1000);
    repeat (3) cyc();
    chk("d_idle", 32'(strobe_out), 0);
    run = 1'b1;
    wait_stb(40, n);
    chk("d_rewarm", n, 22);
    chk("d_val", sx(i_out), 1000);

    // R=8, S=12, then switch to R=2 on a decimation event
    run = 1'b0;
    wr(BASE, 8);
    wr(BASE + 1, 12);
    run = 1'b1;
    wait_stb(60, n);
    chk("e_first", n, 38);
    chk("e_val8", sx(i_out), 1000);
    repeat (2) cyc();
    wr(BASE, 2);
    chk("e_flush", 32'(strobe_out), 0);
    wr(BASE + 1, 4);
    wait_stb(30, n);
    chk("e_restart", n, 13);
    chk("e_val2", sx(i_out), 1000);
    for (int k = 0; k < 2; k++) begin
      cyc();
      wait_stb(10, n);
      chk("e_gap", n + 1, 2);
    end

    // R=1, S=0: identity with STAGES+2 latency
    run = 1'b0;
    q_in = '0;
    wr(BASE, 1);
    wr(BASE + 1, 0);
    hq.delete();
    run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_in = WIDTH'(k * 37 - 300);
      hq.push_back(k * 37 - 300);
      cyc();
      if (k == 8) chk("b_warm", 32'(strobe_out), 0);
      if (k >= 9) begin
        chk("b_stb", 32'(strobe_out), 1);
        chk("b_dly", sx(i_out), hq[hq.size() - 6]);
      end
    end

    // S=2 on steady +/-6 exercises truncation vs rounding
    i_in = 24'd6;
    wr(BASE + 1, 2);
    repeat (8) cyc();
    chk("f_pos6", sx(i_out), EXP_P6);
    i_in = -24'sd6;
    repeat (8) cyc();
    chk("f_neg6", sx(i_out), -2);

    // R=16, S=0: full-scale input overflows and clips
    run = 1'b0;
    wr(BASE, 16);
    wr(BASE + 1, 0);
    i_in = 24'h7FFFFF;
    run  = 1'b1;
    wait_stb(100, n);
    chk("c_first", n, 70);
    chk("c_pos", sx(i_out), 8388607);
    i_in = 24'h800000;
    for (int k = 0; k < 6; k++) begin
      cyc();
      wait_stb(40, n);
    end
    chk("c_neg", sx(i_out), -8388608);

    // Asynchronous reset mid-stream, then warm-up at default R=0, S=0
    i_in  = 24'd500;
    rst_n = 1'b0;
    #1;
    chk("g_rst_i", sx(i_out), 0);
    chk("g_rst_stb", 32'(strobe_out), 0);
    cyc();
    rst_n = 1'b1;
    wait_stb(40, n);
    chk("g_first", n, 10);
    chk("g_val", sx(i_out), 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
